// File: rtl/seg_scan_if.sv
// Bus between the scan controller, the digit pattern mux and the display pins.
// SEG_SCAN_BRIGHTNESS_EN adds the i_duty brightness input.
interface seg_scan_if;
    logic       i_en;
    logic [7:0] i_seg_q;
    logic [3:0] i_blank;
`ifdef SEG_SCAN_BRIGHTNESS_EN
    logic [3:0] i_duty;
`endif
    logic [1:0] o_sel;
    logic [7:0] o_seg_n;
    logic [3:0] o_an_n;
    logic       o_frame;

`ifdef SEG_SCAN_BRIGHTNESS_EN
    modport master (output i_en, i_seg_q, i_blank, i_duty,
                    input  o_sel, o_seg_n, o_an_n, o_frame);
    modport slave  (input  i_en, i_seg_q, i_blank, i_duty,
                    output o_sel, o_seg_n, o_an_n, o_frame);
`else
    modport master (output i_en, i_seg_q, i_blank,
                    input  o_sel, o_seg_n, o_an_n, o_frame);
    modport slave  (input  i_en, i_seg_q, i_blank,
                    output o_sel, o_seg_n, o_an_n, o_frame);
`endif
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 4-digit seven-segment scan controller with a blanking gap per slot.
// Optional SEG_SCAN_BRIGHTNESS_EN: per-frame PWM duty on the anodes.
module seg_scan_ctrl #(
    parameter int unsigned DWELL_CYCLES = 50000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    seg_scan_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(DWELL_CYCLES);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_SHOW  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       sel_q, sel_d;
    logic [7:0]       seg_q, seg_d;
    logic [3:0]       an_q, an_d;
    logic             frame_q, frame_d;
    logic             lit;
`ifdef SEG_SCAN_BRIGHTNESS_EN
    logic [3:0]       pwm_q, pwm_d;
    logic [3:0]       duty_q, duty_d;
`endif

    // State, counters and all display outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sel_q   <= 2'd0;
            seg_q   <= 8'hFF;
            an_q    <= 4'hF;
            frame_q <= 1'b0;
`ifdef SEG_SCAN_BRIGHTNESS_EN
            pwm_q   <= 4'd0;
            duty_q  <= 4'd0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            frame_q <= frame_d;
`ifdef SEG_SCAN_BRIGHTNESS_EN
            pwm_q   <= pwm_d;
            duty_q  <= duty_d;
`endif
        end
    end

    // Next state; outputs are computed for the state being entered so they land together
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        seg_d   = 8'hFF;
        an_d    = 4'hF;
        frame_d = 1'b0;
        lit     = 1'b0;
`ifdef SEG_SCAN_BRIGHTNESS_EN
        pwm_d   = 4'd0;
        duty_d  = duty_q;
        if (frame_q) begin
            duty_d = bus.i_duty;
        end
`endif

        if (!bus.i_en) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            sel_d   = 2'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_BLANK;
                    cnt_d   = '0;
                    sel_d   = 2'd0;
`ifdef SEG_SCAN_BRIGHTNESS_EN
                    duty_d  = bus.i_duty;
`endif
                end
                S_BLANK: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == BLANK_END) begin
                        state_d = S_SHOW;
                    end
                end
                S_SHOW: begin
                    if (cnt_q == LAST_CNT) begin
                        state_d = S_BLANK;
                        cnt_d   = '0;
                        sel_d   = sel_q + 2'd1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    sel_d   = 2'd0;
                end
            endcase
        end

        if (state_d == S_SHOW) begin
            seg_d = ~bus.i_seg_q;
            lit   = !bus.i_blank[sel_d];
`ifdef SEG_SCAN_BRIGHTNESS_EN
            pwm_d = (state_q == S_SHOW) ? pwm_q + 4'd1 : 4'd0;
            lit   = lit && (pwm_d <= duty_q);
`endif
            if (lit) begin
                an_d = ~(4'b0001 << sel_d);
            end
            frame_d = (cnt_d == LAST_CNT) && (sel_d == 2'd3);
        end
    end

    assign bus.o_sel   = sel_q;
    assign bus.o_seg_n = seg_q;
    assign bus.o_an_n  = an_q;
    assign bus.o_frame = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with DWELL=8, BLANK=2; a positional reference
// model pushes expected outputs per cycle and the DUT result is popped and compared.
module tb_seg_scan_ctrl;

    localparam int D = 8;
    localparam int B = 2;

    typedef struct {
        logic [1:0] sel;
        logic [3:0] an;
        logic [7:0] seg;
        logic       fr;
    } exp_t;

    logic clk;
    logic rst_n;
    seg_scan_if bus ();

    seg_scan_ctrl #(.DWELL_CYCLES(D), .BLANK_CYCLES(B)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    logic [7:0] pat [4];
    logic       ovr;
    logic [7:0] ovr_val;
    exp_t       sb [$];
    int         n;
    int         passed;
    int         total;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pattern mux: combinational from o_sel, with an override for live-update checks
    always_comb begin
        bus.i_seg_q = ovr ? ovr_val : pat[bus.o_sel];
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s n=%0d: observed %0h expected %0h", tag, n, obs, exp);
    endtask

    function automatic exp_t model(input int idx);
        exp_t e;
        int   pos;
        int   dig;
        logic [7:0] p;
        e.sel = 2'd0; e.an = 4'hF; e.seg = 8'hFF; e.fr = 1'b0;
        if (idx >= 0) begin
            pos = idx % D;
            dig = (idx / D) % 4;
            p   = ovr ? ovr_val : pat[dig];
            e.sel = 2'(dig);
            if (pos >= B) begin
                e.seg = ~p;
                if (!bus.i_blank[dig]) e.an = ~(4'b0001 << dig);
            end
            e.fr = (pos == D - 1) && (dig == 3);
        end
        return e;
    endfunction

    // One clock: predict from inputs at the edge, then compare mid-cycle
    task automatic step();
        exp_t e;
        if (!bus.i_en) n = -1;
        else if (n < 0) n = 0;
        else n++;
        sb.push_back(model(n));
        @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        chk("sel",   8'(bus.o_sel),   8'(e.sel));
        chk("an",    8'(bus.o_an_n),  8'(e.an));
        chk("seg",   bus.o_seg_n,     e.seg);
        chk("frame", 8'(bus.o_frame), 8'(e.fr));
    endtask

    initial begin
        pat[0] = 8'h3F; pat[1] = 8'h06; pat[2] = 8'h5B; pat[3] = 8'h4F;
        passed = 0; total = 0; n = -1;
        ovr = 1'b0; ovr_val = 8'h00;
        rst_n = 1'b1;
        bus.i_en = 1'b0;
        bus.i_blank = 4'h0;

        #2 rst_n = 1'b0;
        #1;
        chk("rst_sel",   8'(bus.o_sel),   8'h00);
        chk("rst_an",    8'(bus.o_an_n),  8'h0F);
        chk("rst_seg",   bus.o_seg_n,     8'hFF);
        chk("rst_frame", 8'(bus.o_frame), 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Two full frames of normal scanning
        bus.i_en = 1'b1;
        repeat (64) step();

        // Live pattern change in digit 0 SHOW
        repeat (4) step();
        ovr = 1'b1; ovr_val = 8'h06;
        step();
        chk("live_seg", bus.o_seg_n,    8'hF9);
        chk("live_an",  8'(bus.o_an_n), 8'h0E);
        step();
        ovr = 1'b0;
        repeat (3) step();

        // Digit 2 masked for a full frame
        bus.i_blank = 4'b0100;
        repeat (32) step();
        bus.i_blank = 4'h0;

        // Asynchronous reset in the middle of a SHOW
        repeat (3) step();
        chk("pre_rst_an", 8'(bus.o_an_n), 8'h0D);
        #1 rst_n = 1'b0;
        bus.i_en = 1'b0;
        #1;
        chk("mid_rst_sel", 8'(bus.o_sel),  8'h00);
        chk("mid_rst_an",  8'(bus.o_an_n), 8'h0F);
        chk("mid_rst_seg", bus.o_seg_n,    8'hFF);
        #1 rst_n = 1'b1;
        step();

        // Drop enable during digit 1 SHOW, then restart
        bus.i_en = 1'b1;
        repeat (D + B + 2) step();
        chk("d1_lit", 8'(bus.o_an_n), 8'h0D);
        bus.i_en = 1'b0;
        step();
        chk("drop_sel", 8'(bus.o_sel),  8'h00);
        chk("drop_an",  8'(bus.o_an_n), 8'h0F);
        step();
        bus.i_en = 1'b1;
        repeat (B + 1) step();
        chk("reen_an",  8'(bus.o_an_n), 8'h0E);
        chk("reen_seg", bus.o_seg_n,    8'hC0);
        repeat (8) step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for the 4-digit seven-segment display. Drives the digit select into the 4-to-1 pattern multiplexer, registers the returned 8-bit segment pattern, and drives the active-low segment and anode lines with a blanking gap between digits to suppress ghosting. It sits between the clock/time formatting logic (via the mux) and the display pins.

## Interface
- DWELL_CYCLES, 50000: total clock cycles each digit slot lasts (blank + show); must be greater than BLANK_CYCLES.
- BLANK_CYCLES, 500: cycles at the start of each slot with all anodes off; minimum 1.
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_en  in  1  scan enable; low forces the display dark.
- i_seg_q  in  8  segment pattern from the mux for the digit currently on o_sel; active-high, bit 7 = decimal point.
- i_blank  in  4  per-digit blank mask; bit n high keeps digit n dark for its slot.
- o_sel  out  2  digit select to the mux.
- o_seg_n  out  8  registered segment drive, active-low.
- o_an_n  out  4  registered anode drive, active-low, one-hot-low when lit.
- o_frame  out  1  one-cycle pulse on the last cycle of digit 3's slot.

## Operation
- States: IDLE, BLANK, SHOW. A slot counter counts 0..DWELL_CYCLES-1 and a digit counter drives o_sel.
- IDLE: o_an_n = 4'hF, o_seg_n = 8'hFF, o_sel = 0, counters cleared. Leaves to BLANK on the first edge where i_en is high.
- BLANK: anodes off, segments 8'hFF, o_sel holds the new digit so the combinational mux output settles. After BLANK_CYCLES cycles, goes to SHOW.
- SHOW: o_seg_n <= ~i_seg_q every cycle (live updates follow i_seg_q). o_an_n bit o_sel is driven low unless i_blank[o_sel] is high. When the slot counter reaches DWELL_CYCLES-1, o_sel advances (3 wraps to 0) and the state returns to BLANK.
- o_frame pulses on the cycle where the slot counter is DWELL_CYCLES-1 and o_sel = 3.
- i_en low in any state: next edge goes to IDLE with all outputs dark and o_sel = 0. Re-enable always restarts at digit 0, BLANK.
- i_blank is sampled every cycle. A change mid-SHOW takes effect on the next edge.
- Slot counter width = $clog2(DWELL_CYCLES). There is no other arithmetic.

## Timing
- Reset (asynchronous assert): o_sel = 2'd0, o_seg_n = 8'hFF, o_an_n = 4'hF, o_frame = 0, state IDLE. Release is synchronous to i_clk.
- i_en high at edge k gives BLANK from edge k. First lit anode appears at edge k+BLANK_CYCLES.
- o_sel changes on the same edge that enters BLANK. Segment and anode registers update together, so a digit is never lit with the previous digit's pattern.
- Frame period = 4*DWELL_CYCLES cycles. Lit time per digit = DWELL_CYCLES-BLANK_CYCLES cycles.
- Mux path (o_sel to i_seg_q) is combinational and must close in one cycle.

## Configuration
- SEG_SCAN_BRIGHTNESS_EN defined: adds input i_duty [3:0].
  - A 4-bit free-running PWM counter runs during SHOW.
  - The anode is driven low only while pwm_cnt <= duty_q.
  - duty_q is captured from i_duty when o_frame pulses, and when leaving IDLE.
  - i_duty = 15 gives full on. i_duty = 0 gives 1/16 on.
  - Segments are unaffected.
- SEG_SCAN_BRIGHTNESS_EN undefined: the i_duty port does not exist and the anode is lit for all of SHOW.

## Test plan
- Reset mid-SHOW with DWELL=8, BLANK=2: assert i_rst_n=0 -> o_an_n=4'hF, o_seg_n=8'hFF and o_sel=0 immediately, without waiting for a clock.
- i_en=1, i_blank=0, mux returns 8'h3F/06/5B/4F for digits 0..3 -> each digit shows for 6 cycles after 2 dark cycles. o_an_n sequence is E,D,B,7. o_seg_n=~pattern. o_frame pulses every 32 cycles.
- Change i_seg_q from 8'h3F to 8'h06 mid-SHOW -> o_seg_n goes 8'hC0 to 8'hF9 one edge later, with the anode unchanged.
- i_blank=4'b0100 -> digit 2's slot has o_an_n=4'hF throughout. o_sel still steps through 2 and timing is unchanged.
- Drop i_en during digit 1 SHOW -> next edge gives all dark and o_sel=0. Re-raise -> digit 0 lit after exactly BLANK_CYCLES.
- Brightness (macro defined): i_duty=3 -> the lit anode is low 4 of every 16 SHOW cycles. A change to i_duty mid-frame takes effect only after o_frame.
